fetch_queue: RTL and testbench

Instruction prefetch buffer between the fetch stage (PC register plus instruction memory read) and decode. It buffers fetched {instr, pc, pc+4} entries so the PC can keep advancing while decode stalls. Redirects on taken branches and jumps flush it. It uses a valid/ready handshake on both sides and is a circular FIFO of DEPTH entries.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_queue_ctrl.sv | 70 +++++++
 rtl/fetch_queue.sv | 87 ++++++++
 tb/tb_fetch_queue.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants and the buffered fetch entry layout.
package fetch_pkg;

    localparam int          FETCH_ADDR_W  = 32;
    localparam int          FETCH_INSTR_W = 32;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
    localparam logic [31:0] RESET_PC      = 32'hBFC0_0000;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_ADDR_W-1:0]  pcplus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_ctrl.sv
// Pointer/occupancy control for the fetch queue: handshakes, flush and reset priority.
// FETCH_QUEUE_BYPASS_EN enables the empty-queue pass-through path.
module fetch_queue_ctrl
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic          out_ready,
    output logic          in_ready,
    output logic          out_valid,
    output logic          bypass,
    output logic          wr_en,
    output logic [PW-1:0] rd_ptr,
    output logic [PW-1:0] wr_ptr,
    output logic [CW-1:0] count
);

    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          empty_s;
    logic          wr_en_s;
    logic          rd_adv_s;
    logic          bypass_s;

    // Handshake generation; in_ready deliberately ignores out_ready.
    always_comb begin
        empty_s  = (count_r == CW'(0));
        in_ready = (count_r != CW'(DEPTH));
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_s = empty_s & in_valid & ~flush;
`else
        bypass_s = 1'b0;
`endif
        out_valid = ~empty_s | bypass_s;
        // A bypassed entry taken by decode never touches storage or pointers.
        wr_en_s  = in_valid & in_ready & ~flush & ~rst & ~(bypass_s & out_ready);
        rd_adv_s = out_valid & out_ready & ~flush & ~bypass_s;
    end

    // Pointer and occupancy registers; rst outranks flush, flush outranks traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            rd_ptr_r <= rd_ptr_r + PW'(rd_adv_s);
            wr_ptr_r <= wr_ptr_r + PW'(wr_en_s);
            count_r  <= count_r + CW'(wr_en_s) - CW'(rd_adv_s);
        end
    end

    assign bypass = bypass_s;
    assign wr_en  = wr_en_s;
    assign rd_ptr = rd_ptr_r;
    assign wr_ptr = wr_ptr_r;
    assign count  = count_r;

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode prefetch FIFO: entry storage plus head output mux.
// FETCH_QUEUE_BYPASS_EN (in fetch_queue_ctrl) forwards in_* when the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INSTR_WIDTH-1:0]     in_instr,
    input  logic [ADDR_WIDTH-1:0]      in_pc,
    input  logic [ADDR_WIDTH-1:0]      in_pcplus4,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_WIDTH-1:0]     out_instr,
    output logic [ADDR_WIDTH-1:0]      out_pc,
    output logic [ADDR_WIDTH-1:0]      out_pcplus4,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem_r [DEPTH];
    fetch_entry_t  wr_entry_s;
    fetch_entry_t  rd_entry_s;
    logic [PW-1:0] rd_ptr_s;
    logic [PW-1:0] wr_ptr_s;
    logic          wr_en_s;
    logic          bypass_s;

    fetch_queue_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .bypass    (bypass_s),
        .wr_en     (wr_en_s),
        .rd_ptr    (rd_ptr_s),
        .wr_ptr    (wr_ptr_s),
        .count     (count)
    );

    // Pack the incoming fetch bundle into the storage layout.
    always_comb begin
        wr_entry_s.instr   = FETCH_INSTR_W'(in_instr);
        wr_entry_s.pc      = FETCH_ADDR_W'(in_pc);
        wr_entry_s.pcplus4 = FETCH_ADDR_W'(in_pcplus4);
    end

    // Entry storage; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_s] <= wr_entry_s;
        end else begin
            mem_r[wr_ptr_s] <= mem_r[wr_ptr_s];
        end
    end

    // Head mux: pass-through, stored head, or a NOP bubble when nothing is valid.
    always_comb begin
        rd_entry_s = mem_r[rd_ptr_s];
        if (bypass_s) begin
            out_instr   = in_instr;
            out_pc      = in_pc;
            out_pcplus4 = in_pcplus4;
        end else if (out_valid) begin
            out_instr   = INSTR_WIDTH'(rd_entry_s.instr);
            out_pc      = ADDR_WIDTH'(rd_entry_s.pc);
            out_pcplus4 = ADDR_WIDTH'(rd_entry_s.pcplus4);
        end else begin
            out_instr   = INSTR_WIDTH'(NOP_INSTR);
            out_pc      = {ADDR_WIDTH{1'b0}};
            out_pcplus4 = {ADDR_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed table, corner sequences, random traffic vs a queue model.
module tb_fetch_queue;
    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, in_pcplus4, out_instr, out_pc, out_pcplus4;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit model_on = 1'b0;

    typedef struct { logic [31:0] instr; logic [31:0] pc; logic [31:0] pc4; } ent_t;
    ent_t q[$];

    typedef struct {
        logic rst; logic flush; logic iv; logic [31:0] pc; logic ordy;
        logic chk; logic [2:0] cnt; logic ir; logic ov; logic [31:0] opc;
    } vec_t;
    vec_t vecs[13];

    fetch_queue #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_pcplus4(in_pcplus4),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pcplus4(out_pcplus4), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic void compare_model();
        bit   byp;
        ent_t e;
        byp = BYP && (q.size() == 0) && in_valid && !flush;
        if (byp) e = '{instr: in_instr, pc: in_pc, pc4: in_pcplus4};
        else if (q.size() > 0) e = q[0];
        else e = '{instr: 32'h0000_0013, pc: 32'h0, pc4: 32'h0};
        chk("m_count", count, q.size());
        chk("m_in_ready", in_ready, q.size() != DEPTH);
        chk("m_out_valid", out_valid, (q.size() > 0) || byp);
        chk("m_out_instr", out_instr, e.instr);
        chk("m_out_pc", out_pc, e.pc);
        chk("m_out_pcplus4", out_pcplus4, e.pc4);
    endfunction

    function automatic void update_model();
        bit push, pop, byp;
        if (rst) begin
            q.delete();
            model_on = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            byp  = BYP && (q.size() == 0) && in_valid;
            push = in_valid && (q.size() < DEPTH);
            pop  = (q.size() > 0) && out_ready;
            if (!(byp && out_ready)) begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back('{instr: in_instr, pc: in_pc, pc4: in_pcplus4});
            end
        end
    endfunction

    task automatic apply(input logic r, input logic f, input logic v, input logic [31:0] pc, input logic o);
        rst = r; flush = f; in_valid = v; in_pc = pc;
        in_instr = instr_of(pc); in_pcplus4 = pc + 32'd4; out_ready = o;
        #3;
        if (model_on) compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        update_model();
        cyc++;
        #1;
    endtask

    initial begin
        logic [31:0] prev_pc;
        logic [31:0] pc;
        logic [31:0] first_pc;
        first_pc = BYP ? 32'hBFC0_0000 : 32'h0;
        //         rst  fl   iv   pc            ordy chk  cnt   ir   ov    out_pc
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'hBFC0_0000, 1'b0, 1'b1, 3'd0, 1'b1, BYP, first_pc};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'hBFC0_0004, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 32'hBFC0_0000};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'hBFC0_0008, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, 32'hBFC0_0000};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'hBFC0_000C, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 32'hBFC0_0000};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'hBFC0_0010, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 32'hBFC0_0000};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 32'hBFC0_0000};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 32'hBFC0_0004};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 32'hBFC0_0008};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 32'hBFC0_000C};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 32'h0};

        // Reset, idle, fill past full, drain.
        for (int i = 0; i < 13; i++) begin
            apply(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
            if (vecs[i].chk) begin
                chk("t_count", count, vecs[i].cnt);
                chk("t_in_ready", in_ready, vecs[i].ir);
                chk("t_out_valid", out_valid, vecs[i].ov);
                chk("t_out_pc", out_pc, vecs[i].opc);
                if (!vecs[i].ov) chk("t_out_instr_nop", out_instr, 32'h0000_0013);
            end
            tick();
        end

        // Steady streaming across pointer wrap.
        prev_pc = 32'h0;
        for (int i = 0; i < 10; i++) begin
            pc = 32'h0000_1000 + 32'(i) * 32'd4;
            apply(1'b0, 1'b0, 1'b1, pc, 1'b1);
            if (i > 0) begin
                chk("s_count", count, BYP ? 3'd0 : 3'd1);
                chk("s_out_pc", out_pc, BYP ? pc : prev_pc);
            end
            tick();
            prev_pc = pc;
        end
        for (int i = 0; i < 2; i++) begin apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); tick(); end

        // Flush with a simultaneous push.
        for (int i = 0; i < 3; i++) begin apply(1'b0, 1'b0, 1'b1, 32'h8000_0000 + 32'(i) * 32'd4, 1'b0); tick(); end
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("f_count_pre", count, 3'd3);
        apply(1'b0, 1'b1, 1'b1, 32'h8000_0020, 1'b0); tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("f_count", count, 3'd0);
        chk("f_out_valid", out_valid, 1'b0);
        tick();
        apply(1'b0, 1'b0, 1'b1, 32'h8000_0020, 1'b0); tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("f_out_pc", out_pc, 32'h8000_0020);
        chk("f_count_after", count, 3'd1);
        tick();

        // rst and flush together at count=2.
        apply(1'b0, 1'b0, 1'b1, 32'h8000_0040, 1'b0); tick();
        apply(1'b1, 1'b1, 1'b1, 32'h8000_0044, 1'b1); tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("r_count", count, 3'd0);
        chk("r_rd_ptr", dut.rd_ptr_s, 2'd0);
        chk("r_wr_ptr", dut.wr_ptr_s, 2'd0);
        tick();
        apply(1'b0, 1'b0, 1'b1, 32'h8000_0100, 1'b0); tick();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("r_entry0_pc", dut.mem_r[0].pc, 32'h8000_0100);
        chk("r_out_pc", out_pc, 32'h8000_0100);
        tick();

        // Backpressure at full with a single out_ready pulse.
        for (int i = 1; i < 4; i++) begin apply(1'b0, 1'b0, 1'b1, 32'h8000_0100 + 32'(i) * 32'd4, 1'b0); tick(); end
        apply(1'b0, 1'b0, 1'b1, 32'h9000_0000, 1'b1);
        chk("b_count_full", count, 3'd4);
        chk("b_in_ready_full", in_ready, 1'b0);
        tick();
        apply(1'b0, 1'b0, 1'b1, 32'h9000_0000, 1'b0);
        chk("b_count_after", count, 3'd3);
        chk("b_in_ready_after", in_ready, 1'b1);
        chk("b_head", out_pc, 32'h8000_0104);
        tick();
        for (int i = 0; i < 5; i++) begin apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); tick(); end

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            apply($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0,
                  1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
